// File: rtl/picorv_trace_capture_if.sv
// AXI4-Lite slave bus for the PicoRV32 trace capture block.
// Handshake: a beat transfers on a rising edge where valid and ready are both high;
// valid, once raised, holds its payload stable until that edge.
interface picorv_trace_capture_if;
    logic [4:0]  s_awaddr;
    logic        s_awvalid;
    logic        s_awready;
    logic [31:0] s_wdata;
    logic [3:0]  s_wstrb;
    logic        s_wvalid;
    logic        s_wready;
    logic [1:0]  s_bresp;
    logic        s_bvalid;
    logic        s_bready;
    logic [4:0]  s_araddr;
    logic        s_arvalid;
    logic        s_arready;
    logic [31:0] s_rdata;
    logic [1:0]  s_rresp;
    logic        s_rvalid;
    logic        s_rready;

    modport slave (
        input  s_awaddr, s_awvalid, s_wdata, s_wstrb, s_wvalid, s_bready,
        input  s_araddr, s_arvalid, s_rready,
        output s_awready, s_wready, s_bresp, s_bvalid,
        output s_arready, s_rdata, s_rresp, s_rvalid
    );

    modport master (
        output s_awaddr, s_awvalid, s_wdata, s_wstrb, s_wvalid, s_bready,
        output s_araddr, s_arvalid, s_rready,
        input  s_awready, s_wready, s_bresp, s_bvalid,
        input  s_arready, s_rdata, s_rresp, s_rvalid
    );
endinterface

// File: rtl/picorv_trace_capture.sv
// PicoRV32 trace-word FIFO drained over AXI4-Lite.
// Optional threshold interrupt and THRESH register: define TRACE_CAPTURE_IRQ_EN.
module picorv_trace_capture #(
    parameter int DEPTH = 256,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic                      G0_CPU_CLK,
    input  logic                      G0_CPU_RST_N,
    input  logic                      trace_valid,
    input  logic [35:0]               trace_data,
    input  logic                      trap,
    picorv_trace_capture_if.slave     s
`ifdef TRACE_CAPTURE_IRQ_EN
    ,
    output logic                      o_irq
`endif
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    logic [35:0]   mem_q [DEPTH];
    logic [AW-1:0] head_q, head_d, tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;
    logic [11:0]   overflow_q, overflow_d;
    logic          trap_seen_q, trap_seen_d;
    logic [3:0]    hold_q, hold_d;
    logic          enable_q, enable_d;
    logic          wrap_q, wrap_d;
    logic          bvalid_q, bvalid_d;
    logic [1:0]    bresp_q, bresp_d;
    logic          rvalid_q, rvalid_d;
    logic [31:0]   rdata_q, rdata_d;
    logic [1:0]    rresp_q, rresp_d;
`ifdef TRACE_CAPTURE_IRQ_EN
    logic [CW-1:0] thresh_q, thresh_d;
    logic          irq_q, irq_d;
    logic [31:0]   thresh_merged;
`endif

    logic        aw_fire, ar_fire, empty, full, clear, push, pop, mem_we;
    logic [35:0] head_word;
    logic [31:0] wmask, status;
    logic        unused_bits;

    // AW and W are only taken as a pair, so the master must present both together.
    assign s.s_awready = ~bvalid_q;
    assign s.s_wready  = ~bvalid_q;
    assign s.s_bvalid  = bvalid_q;
    assign s.s_bresp   = bresp_q;
    assign s.s_arready = ~rvalid_q;
    assign s.s_rvalid  = rvalid_q;
    assign s.s_rdata   = rdata_q;
    assign s.s_rresp   = rresp_q;
`ifdef TRACE_CAPTURE_IRQ_EN
    assign o_irq = irq_q;
`endif

    assign unused_bits = ^{s.s_wdata, s.s_wstrb};

    always_comb begin
        aw_fire   = s.s_awvalid & s.s_wvalid & ~bvalid_q;
        ar_fire   = s.s_arvalid & ~rvalid_q;
        wmask     = {{8{s.s_wstrb[3]}}, {8{s.s_wstrb[2]}}, {8{s.s_wstrb[1]}}, {8{s.s_wstrb[0]}}};
        empty     = (count_q == '0);
        full      = (count_q == CW'(DEPTH));
        head_word = mem_q[head_q];
        clear     = aw_fire & (s.s_awaddr == 5'h0C) & s.s_wstrb[0] & s.s_wdata[1];
        push      = trace_valid & enable_q & ~trap_seen_q & ~clear;
        pop       = ar_fire & (s.s_araddr == 5'h04) & ~empty;
        mem_we    = push & (~full | pop | wrap_q);

        status             = '0;
        status[CW-1:0]     = count_q;
        status[16]         = empty;
        status[17]         = full;
        status[18]         = trap_seen_q;
        status[31:20]      = overflow_q;

        head_d      = head_q;
        tail_d      = tail_q;
        count_d     = count_q;
        overflow_d  = overflow_q;
        trap_seen_d = trap_seen_q | trap;
        hold_d      = hold_q;
        enable_d    = enable_q;
        wrap_d      = wrap_q;
        bvalid_d    = bvalid_q;
        bresp_d     = bresp_q;
        rvalid_d    = rvalid_q;
        rdata_d     = rdata_q;
        rresp_d     = rresp_q;
`ifdef TRACE_CAPTURE_IRQ_EN
        thresh_d      = thresh_q;
        thresh_merged = (32'(thresh_q) & ~wmask) | (s.s_wdata & wmask);
        irq_d         = ((thresh_q != '0) && (count_q >= thresh_q)) || (overflow_q != '0);
`endif

        // A simultaneous push and pop keeps the count, even when full.
        if (push && pop) begin
            tail_d = tail_q + AW'(1);
            head_d = head_q + AW'(1);
        end else if (push && !full) begin
            tail_d  = tail_q + AW'(1);
            count_d = count_q + CW'(1);
        end else if (push) begin
            if (overflow_q != 12'hFFF) overflow_d = overflow_q + 12'd1;
            if (wrap_q) begin
                tail_d = tail_q + AW'(1);
                head_d = head_q + AW'(1);
            end
        end else if (pop) begin
            head_d  = head_q + AW'(1);
            count_d = count_q - CW'(1);
        end
        if (pop) hold_d = head_word[35:32];

        if (aw_fire) begin
            bvalid_d = 1'b1;
            bresp_d  = RESP_OKAY;
            case (s.s_awaddr)
                5'h00, 5'h04, 5'h08: ;
                5'h0C: begin
                    if (s.s_wstrb[0]) begin
                        enable_d = s.s_wdata[0];
                        wrap_d   = s.s_wdata[2];
                    end
                end
`ifdef TRACE_CAPTURE_IRQ_EN
                5'h10: thresh_d = thresh_merged[CW-1:0];
`endif
                default: bresp_d = RESP_SLVERR;
            endcase
        end else if (s.s_bready) begin
            bvalid_d = 1'b0;
        end

        if (ar_fire) begin
            rvalid_d = 1'b1;
            rresp_d  = RESP_OKAY;
            rdata_d  = '0;
            case (s.s_araddr)
                5'h00: rdata_d = status;
                5'h04: rdata_d = empty ? 32'h0 : head_word[31:0];
                5'h08: rdata_d = {28'h0, hold_q};
                5'h0C: rdata_d = {29'h0, wrap_q, 1'b0, enable_q};
`ifdef TRACE_CAPTURE_IRQ_EN
                5'h10: rdata_d = 32'(thresh_q);
`endif
                default: rresp_d = RESP_SLVERR;
            endcase
        end else if (s.s_rready) begin
            rvalid_d = 1'b0;
        end

        if (clear) begin
            head_d      = '0;
            tail_d      = '0;
            count_d     = '0;
            overflow_d  = '0;
            trap_seen_d = 1'b0;
            hold_d      = '0;
        end
    end

    always_ff @(posedge G0_CPU_CLK) begin
        if (mem_we) mem_q[tail_q] <= trace_data;
    end

    always_ff @(posedge G0_CPU_CLK or negedge G0_CPU_RST_N) begin
        if (!G0_CPU_RST_N) begin
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
            overflow_q  <= '0;
            trap_seen_q <= 1'b0;
            hold_q      <= '0;
            enable_q    <= 1'b1;
            wrap_q      <= 1'b0;
            bvalid_q    <= 1'b0;
            bresp_q     <= RESP_OKAY;
            rvalid_q    <= 1'b0;
            rdata_q     <= '0;
            rresp_q     <= RESP_OKAY;
`ifdef TRACE_CAPTURE_IRQ_EN
            thresh_q    <= '0;
            irq_q       <= 1'b0;
`endif
        end else begin
            head_q      <= head_d;
            tail_q      <= tail_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            trap_seen_q <= trap_seen_d;
            hold_q      <= hold_d;
            enable_q    <= enable_d;
            wrap_q      <= wrap_d;
            bvalid_q    <= bvalid_d;
            bresp_q     <= bresp_d;
            rvalid_q    <= rvalid_d;
            rdata_q     <= rdata_d;
            rresp_q     <= rresp_d;
`ifdef TRACE_CAPTURE_IRQ_EN
            thresh_q    <= thresh_d;
            irq_q       <= irq_d;
`endif
        end
    end
endmodule

// File: tb/tb_picorv_trace_capture.sv
// Directed bench: two instances (DEPTH=8 as "a", DEPTH=4 as "b") share one stimulus stream.
module tb_picorv_trace_capture;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        trace_valid, trap;
    logic [35:0] trace_data;
    logic [4:0]  awaddr, araddr;
    logic        awvalid, wvalid, bready, arvalid, rready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    int          checks = 0;
    int          failures = 0;

    always #5 clk = ~clk;

    picorv_trace_capture_if bus_a ();
    picorv_trace_capture_if bus_b ();

    assign bus_a.s_awaddr = awaddr;  assign bus_b.s_awaddr = awaddr;
    assign bus_a.s_awvalid = awvalid; assign bus_b.s_awvalid = awvalid;
    assign bus_a.s_wdata = wdata;    assign bus_b.s_wdata = wdata;
    assign bus_a.s_wstrb = wstrb;    assign bus_b.s_wstrb = wstrb;
    assign bus_a.s_wvalid = wvalid;  assign bus_b.s_wvalid = wvalid;
    assign bus_a.s_bready = bready;  assign bus_b.s_bready = bready;
    assign bus_a.s_araddr = araddr;  assign bus_b.s_araddr = araddr;
    assign bus_a.s_arvalid = arvalid; assign bus_b.s_arvalid = arvalid;
    assign bus_a.s_rready = rready;  assign bus_b.s_rready = rready;

`ifdef TRACE_CAPTURE_IRQ_EN
    logic irq_a, irq_b;
`endif

    picorv_trace_capture #(.DEPTH(8)) dut_a (
        .G0_CPU_CLK(clk), .G0_CPU_RST_N(rst_n), .trace_valid(trace_valid),
        .trace_data(trace_data), .trap(trap), .s(bus_a)
`ifdef TRACE_CAPTURE_IRQ_EN
        , .o_irq(irq_a)
`endif
    );

    picorv_trace_capture #(.DEPTH(4)) dut_b (
        .G0_CPU_CLK(clk), .G0_CPU_RST_N(rst_n), .trace_valid(trace_valid),
        .trace_data(trace_data), .trap(trap), .s(bus_b)
`ifdef TRACE_CAPTURE_IRQ_EN
        , .o_irq(irq_b)
`endif
    );

    task automatic push(input logic [35:0] d);
        @(negedge clk); trace_valid = 1'b1; trace_data = d;
        @(negedge clk); trace_valid = 1'b0;
    endtask

    task automatic axi_write(input logic [4:0] addr, input logic [31:0] data, input logic [3:0] strb,
                             output logic [1:0] ra, output logic [1:0] rb);
        int n;
        @(negedge clk); awaddr = addr; wdata = data; wstrb = strb; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
        n = 0;
        while (!bus_a.s_awready && n < 20) begin @(negedge clk); n++; end
        @(negedge clk); awvalid = 1'b0; wvalid = 1'b0;
        checks++;
        if (bus_a.s_bvalid !== 1'b1 || bus_a.s_awready !== 1'b0) begin
            failures++;
            $display("FAIL wr_latency addr=%h bvalid=%b awready=%b required bvalid=1 awready=0", addr, bus_a.s_bvalid, bus_a.s_awready);
        end
        n = 0;
        while (!bus_a.s_bvalid && n < 20) begin @(negedge clk); n++; end
        ra = bus_a.s_bresp; rb = bus_b.s_bresp;
        bready = 1'b1;
        @(negedge clk); bready = 1'b0;
    endtask

    task automatic axi_read(input logic [4:0] addr, output logic [31:0] da, output logic [31:0] db,
                            output logic [1:0] ra, output logic [1:0] rb);
        int n;
        @(negedge clk); araddr = addr; arvalid = 1'b1; rready = 1'b0;
        n = 0;
        while (!bus_a.s_arready && n < 20) begin @(negedge clk); n++; end
        @(negedge clk); arvalid = 1'b0;
        checks++;
        if (bus_a.s_rvalid !== 1'b1 || bus_a.s_arready !== 1'b0) begin
            failures++;
            $display("FAIL rd_latency addr=%h rvalid=%b arready=%b required rvalid=1 arready=0", addr, bus_a.s_rvalid, bus_a.s_arready);
        end
        n = 0;
        while (!bus_a.s_rvalid && n < 20) begin @(negedge clk); n++; end
        da = bus_a.s_rdata; db = bus_b.s_rdata; ra = bus_a.s_rresp; rb = bus_b.s_rresp;
        rready = 1'b1;
        @(negedge clk); rready = 1'b0;
    endtask

    logic [31:0] da, db;
    logic [1:0]  ra, rb;

    task automatic test_reset();
        rst_n = 1'b0; trace_valid = 1'b0; trace_data = '0; trap = 1'b0;
        awaddr = '0; araddr = '0; awvalid = 1'b0; wvalid = 1'b0; bready = 1'b0;
        arvalid = 1'b0; rready = 1'b0; wdata = '0; wstrb = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({bus_a.s_awready, bus_a.s_wready, bus_a.s_arready, bus_a.s_bvalid, bus_a.s_rvalid} !== 5'b11100) begin
            failures++;
            $display("FAIL reset_handshake got=%b required=11100",
                     {bus_a.s_awready, bus_a.s_wready, bus_a.s_arready, bus_a.s_bvalid, bus_a.s_rvalid});
        end
        checks++;
        if ({bus_a.s_rdata, bus_a.s_rresp, bus_a.s_bresp} !== 36'h0) begin
            failures++;
            $display("FAIL reset_data got rdata=%h rresp=%b bresp=%b required 0", bus_a.s_rdata, bus_a.s_rresp, bus_a.s_bresp);
        end
`ifdef TRACE_CAPTURE_IRQ_EN
        checks++;
        if (irq_a !== 1'b0) begin failures++; $display("FAIL reset_irq got=%b required=0", irq_a); end
`endif
        axi_read(5'h00, da, db, ra, rb);
        checks++;
        if (da !== 32'h0001_0000) begin failures++; $display("FAIL reset_status got=%h required=00010000", da); end
        axi_read(5'h0C, da, db, ra, rb);
        checks++;
        if (da !== 32'h1) begin failures++; $display("FAIL reset_ctrl got=%h required=00000001", da); end
    endtask

    task automatic test_fifo_order();
        logic [31:0] exp_b;
        for (int i = 1; i <= 5; i++) push(36'(i));
        axi_read(5'h00, da, db, ra, rb);
        checks++;
        if (da !== 32'h5) begin failures++; $display("FAIL order_count got=%h required=00000005", da); end
        for (int i = 1; i <= 5; i++) begin
            exp_b = (i <= 4) ? 32'(i) : 32'h0;
            axi_read(5'h04, da, db, ra, rb);
            checks++;
            if (da !== 32'(i) || ra !== 2'b00) begin
                failures++; $display("FAIL order_pop_a[%0d] got=%h/%b required=%h/00", i, da, ra, i);
            end
            checks++;
            if (db !== exp_b) begin failures++; $display("FAIL order_pop_b[%0d] got=%h required=%h", i, db, exp_b); end
        end
        axi_read(5'h00, da, db, ra, rb);
        checks++;
        if (da !== 32'h0001_0000) begin failures++; $display("FAIL order_empty_a got=%h required=00010000", da); end
        checks++;
        if (db !== 32'h0011_0000) begin failures++; $display("FAIL order_ovf_b got=%h required=00110000", db); end
        axi_write(5'h0C, 32'h3, 4'h1, ra, rb);
        axi_read(5'h00, da, db, ra, rb);
        checks++;
        if (db !== 32'h0001_0000) begin failures++; $display("FAIL clear_ovf_b got=%h required=00010000", db); end
    endtask

    task automatic test_hold();
        push(36'hA_DEAD_BEEF);
        axi_read(5'h04, da, db, ra, rb);
        checks++;
        if (da !== 32'hDEAD_BEEF) begin failures++; $display("FAIL hold_lo got=%h required=deadbeef", da); end
        axi_read(5'h08, da, db, ra, rb);
        checks++;
        if (da !== 32'hA) begin failures++; $display("FAIL hold_hi got=%h required=0000000a", da); end
        axi_read(5'h04, da, db, ra, rb);
        checks++;
        if (da !== 32'h0 || ra !== 2'b00) begin failures++; $display("FAIL empty_lo got=%h/%b required=00000000/00", da, ra); end
        axi_read(5'h08, da, db, ra, rb);
        checks++;
        if (da !== 32'hA) begin failures++; $display("FAIL hold_kept got=%h required=0000000a", da); end
    endtask

    task automatic test_overflow();
        for (int i = 1; i <= 6; i++) push(36'(i));
        axi_read(5'h00, da, db, ra, rb);
        checks++;
        if (db !== 32'h0022_0004) begin failures++; $display("FAIL drop_status got=%h required=00220004", db); end
        for (int i = 1; i <= 4; i++) begin
            axi_read(5'h04, da, db, ra, rb);
            checks++;
            if (db !== 32'(i)) begin failures++; $display("FAIL drop_pop[%0d] got=%h required=%h", i, db, i); end
        end
        axi_write(5'h0C, 32'h7, 4'h1, ra, rb);
        for (int i = 1; i <= 6; i++) push(36'(i));
        axi_read(5'h00, da, db, ra, rb);
        checks++;
        if (db !== 32'h0022_0004) begin failures++; $display("FAIL wrap_status got=%h required=00220004", db); end
        for (int i = 3; i <= 6; i++) begin
            axi_read(5'h04, da, db, ra, rb);
            checks++;
            if (db !== 32'(i)) begin failures++; $display("FAIL wrap_pop[%0d] got=%h required=%h", i, db, i); end
        end
        axi_read(5'h00, da, db, ra, rb);
        checks++;
        if (db !== 32'h0021_0000) begin failures++; $display("FAIL wrap_after got=%h required=00210000", db); end
        axi_read(5'h0C, da, db, ra, rb);
        checks++;
        if (db !== 32'h5) begin failures++; $display("FAIL wrap_ctrl got=%h required=00000005", db); end
    endtask

    task automatic test_push_pop_full();
        int n;
        axi_write(5'h0C, 32'h3, 4'h1, ra, rb);
        for (int i = 1; i <= 4; i++) push(36'(i));
        @(negedge clk);
        trace_valid = 1'b1; trace_data = 36'h9; araddr = 5'h04; arvalid = 1'b1; rready = 1'b0;
        @(negedge clk);
        trace_valid = 1'b0; arvalid = 1'b0;
        n = 0;
        while (!bus_b.s_rvalid && n < 20) begin @(negedge clk); n++; end
        checks++;
        if (bus_b.s_rdata !== 32'h1) begin failures++; $display("FAIL pp_rdata got=%h required=00000001", bus_b.s_rdata); end
        rready = 1'b1;
        @(negedge clk); rready = 1'b0;
        axi_read(5'h00, da, db, ra, rb);
        checks++;
        if (db !== 32'h0002_0004) begin failures++; $display("FAIL pp_status got=%h required=00020004", db); end
        for (int i = 0; i < 4; i++) begin
            logic [31:0] e;
            e = (i < 3) ? 32'(i + 2) : 32'h9;
            axi_read(5'h04, da, db, ra, rb);
            checks++;
            if (db !== e) begin failures++; $display("FAIL pp_pop[%0d] got=%h required=%h", i, db, e); end
        end
    endtask

    task automatic test_trap();
        axi_write(5'h0C, 32'h3, 4'h1, ra, rb);
        @(negedge clk); trace_valid = 1'b1; trace_data = 36'h11;
        @(negedge clk);
        @(negedge clk); trap = 1'b1;
        @(negedge clk); trap = 1'b0;
        repeat (3) @(negedge clk);
        trace_valid = 1'b0;
        axi_read(5'h00, da, db, ra, rb);
        checks++;
        if (da !== 32'h0004_0003) begin failures++; $display("FAIL trap_status got=%h required=00040003", da); end
        axi_write(5'h0C, 32'h3, 4'h1, ra, rb);
        axi_read(5'h00, da, db, ra, rb);
        checks++;
        if (da !== 32'h0001_0000) begin failures++; $display("FAIL trap_clear got=%h required=00010000", da); end
        push(36'h22);
        axi_read(5'h00, da, db, ra, rb);
        checks++;
        if (da !== 32'h1) begin failures++; $display("FAIL trap_resume got=%h required=00000001", da); end
        axi_read(5'h04, da, db, ra, rb);
        checks++;
        if (da !== 32'h22) begin failures++; $display("FAIL trap_data got=%h required=00000022", da); end
    endtask

    task automatic test_ctrl_regs();
        axi_write(5'h0C, 32'h0, 4'h1, ra, rb);
        push(36'h33);
        axi_read(5'h00, da, db, ra, rb);
        checks++;
        if (da !== 32'h0001_0000) begin failures++; $display("FAIL disabled_count got=%h required=00010000", da); end
        axi_write(5'h0C, 32'h1, 4'h0, ra, rb);
        axi_read(5'h0C, da, db, ra, rb);
        checks++;
        if (da !== 32'h0) begin failures++; $display("FAIL strb_ignored got=%h required=00000000", da); end
        axi_write(5'h0C, 32'h1, 4'h1, ra, rb);
        axi_write(5'h00, 32'hFFFF_FFFF, 4'hF, ra, rb);
        checks++;
        if (ra !== 2'b00) begin failures++; $display("FAIL ro_write_resp got=%b required=00", ra); end
        axi_write(5'h14, 32'h1, 4'hF, ra, rb);
        checks++;
        if (ra !== 2'b10) begin failures++; $display("FAIL unmapped_wr got=%b required=10", ra); end
        axi_read(5'h14, da, db, ra, rb);
        checks++;
        if (da !== 32'h0 || ra !== 2'b10) begin failures++; $display("FAIL unmapped_rd got=%h/%b required=00000000/10", da, ra); end
`ifndef TRACE_CAPTURE_IRQ_EN
        axi_write(5'h10, 32'h3, 4'hF, ra, rb);
        checks++;
        if (ra !== 2'b10) begin failures++; $display("FAIL thresh_wr_noirq got=%b required=10", ra); end
        axi_read(5'h10, da, db, ra, rb);
        checks++;
        if (da !== 32'h0 || ra !== 2'b10) begin failures++; $display("FAIL thresh_rd_noirq got=%h/%b required=00000000/10", da, ra); end
`endif
    endtask

`ifdef TRACE_CAPTURE_IRQ_EN
    task automatic test_irq();
        axi_write(5'h0C, 32'h3, 4'h1, ra, rb);
        axi_write(5'h10, 32'h3, 4'hF, ra, rb);
        checks++;
        if (ra !== 2'b00) begin failures++; $display("FAIL thresh_wr got=%b required=00", ra); end
        push(36'h1); push(36'h2); push(36'h3);
        checks++;
        if (irq_a !== 1'b0) begin failures++; $display("FAIL irq_early got=%b required=0", irq_a); end
        @(negedge clk);
        checks++;
        if (irq_a !== 1'b1) begin failures++; $display("FAIL irq_set got=%b required=1", irq_a); end
        axi_read(5'h04, da, db, ra, rb);
        @(negedge clk);
        checks++;
        if (irq_a !== 1'b0) begin failures++; $display("FAIL irq_clear got=%b required=0", irq_a); end
        axi_read(5'h10, da, db, ra, rb);
        checks++;
        if (da !== 32'h3) begin failures++; $display("FAIL thresh_rd got=%h required=00000003", da); end
    endtask
`endif

    task automatic test_reset_abort();
        @(negedge clk);
        awaddr = 5'h0C; wdata = 32'h1; wstrb = 4'h1; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
        araddr = 5'h00; arvalid = 1'b1; rready = 1'b0;
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        checks++;
        if ({bus_a.s_bvalid, bus_a.s_rvalid} !== 2'b11) begin
            failures++; $display("FAIL abort_pending got=%b required=11", {bus_a.s_bvalid, bus_a.s_rvalid});
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({bus_a.s_bvalid, bus_a.s_rvalid} !== 2'b00) begin
            failures++; $display("FAIL abort_async got=%b required=00", {bus_a.s_bvalid, bus_a.s_rvalid});
        end
        @(negedge clk); rst_n = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({bus_a.s_bvalid, bus_a.s_rvalid, bus_a.s_arready, bus_a.s_awready} !== 4'b0011) begin
            failures++;
            $display("FAIL abort_after got=%b required=0011", {bus_a.s_bvalid, bus_a.s_rvalid, bus_a.s_arready, bus_a.s_awready});
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_fifo_order();
        test_hold();
        test_overflow();
        test_push_pop_full();
        test_trap();
        test_ctrl_regs();
`ifdef TRACE_CAPTURE_IRQ_EN
        test_irq();
`endif
        test_reset_abort();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
